// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard/stall controller: FSM state encoding,
// register-index width and memory-wait counter width.
// Imported by hazard_ctrl and wait_timer.
package hazard_pkg;

  localparam int REG_W = 5;  // MIPS register index width
  localparam int CNT_W = 8;  // memory-wait counter width

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_TIMEOUT  = 2'd2
  } state_t;

  // True when a load in EX writes a register the ID instruction reads.
  // R0 is never a real dependency because it is hardwired to zero.
  function automatic logic load_use(input logic             mem_read,
                                    input logic [REG_W-1:0] wr,
                                    input logic [REG_W-1:0] rs,
                                    input logic [REG_W-1:0] rt,
                                    input logic             uses_rt);
    return mem_read && (wr != '0) && ((wr == rs) || (uses_rt && (wr == rt)));
  endfunction

endpackage

// File: rtl/wait_timer.sv
// Memory-wait cycle counter for hazard_ctrl.
// Ports: clk/reset; start_i loads 1, inc_i increments (saturating, never
// wraps), clr_i clears; expired_o is high while the count equals WAIT_MAX.
module wait_timer
  import hazard_pkg::*;
#(
  parameter int WAIT_MAX = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic expired_o
);

  localparam logic [CNT_W-1:0] WAIT_MAX_C = CNT_W'(WAIT_MAX);
  localparam logic [CNT_W-1:0] CNT_SAT    = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (start_i) begin
      // The cycle that raises the request already counts as the first wait.
      cnt_d = CNT_W'(1);
    end else if (inc_i && (cnt_q != CNT_SAT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == WAIT_MAX_C);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use bubbles, branch squash,
// memory-busy freeze and sticky memory timeout for the 5-stage MIPS core.
// Inputs: hazard operands from EX/ID, Branch, MemReq_mem/MemReady.
// Outputs: IFWrite, IDEXFlush, PipeHold (combinational), MemTimeout and
// State (registered). Optional macro HAZARD_PERF_CNT_EN adds three
// saturating 32-bit counters LuStallCnt, FlushCnt, MemWaitCnt.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int WAIT_MAX = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemRead_ex,
  input  logic [REG_W-1:0] WriteReg_ex,
  input  logic [REG_W-1:0] Rs_id,
  input  logic [REG_W-1:0] Rt_id,
  input  logic             UsesRt_id,
  input  logic             Branch,
  input  logic             MemReq_mem,
  input  logic             MemReady,
  output logic             IFWrite,
  output logic             IDEXFlush,
  output logic             PipeHold,
  output logic             MemTimeout,
  output logic [1:0]       State
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]      LuStallCnt,
  output logic [31:0]      FlushCnt,
  output logic [31:0]      MemWaitCnt
`endif
);

  state_t state_q, state_d;

  logic lu;
  logic ifw, flush, hold;
  logic run_eval;
  logic br_flush, lu_stall;
  logic tmr_start, tmr_inc, tmr_clr, tmr_expired;

  assign lu = load_use(MemRead_ex, WriteReg_ex, Rs_id, Rt_id, UsesRt_id);

  wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_timer (
    .clk       (clk),
    .reset     (reset),
    .start_i   (tmr_start),
    .inc_i     (tmr_inc),
    .clr_i     (tmr_clr),
    .expired_o (tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ifw       = 1'b1;
    flush     = 1'b0;
    hold      = 1'b0;
    run_eval  = 1'b0;
    br_flush  = 1'b0;
    lu_stall  = 1'b0;
    tmr_start = 1'b0;
    tmr_inc   = 1'b0;
    tmr_clr   = 1'b0;

    case (state_q)
      ST_RUN: begin
        run_eval = 1'b1;
      end
      ST_MEM_WAIT: begin
        if (MemReady) begin
          // Release: the frozen EX/ID instructions are evaluated normally
          // in the ack cycle itself.
          run_eval = 1'b1;
          state_d  = ST_RUN;
          tmr_clr  = 1'b1;
        end else begin
          hold = 1'b1;
          ifw  = 1'b0;
          if (tmr_expired) begin
            state_d = ST_TIMEOUT;
          end else begin
            tmr_inc = 1'b1;
          end
        end
      end
      ST_TIMEOUT: begin
        // Terminal until reset; MemReady is deliberately ignored here.
        hold = 1'b1;
        ifw  = 1'b0;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    if (run_eval) begin
      if (MemReq_mem && !MemReady) begin
        hold      = 1'b1;
        ifw       = 1'b0;
        state_d   = ST_MEM_WAIT;
        tmr_start = 1'b1;
      end else if (Branch) begin
        // Branch wins over load-use: the stalled ID instruction is squashed.
        flush    = 1'b1;
        br_flush = 1'b1;
      end else if (lu) begin
        // One bubble suffices: the load reaches MEM on the next edge.
        ifw      = 1'b0;
        flush    = 1'b1;
        lu_stall = 1'b1;
      end
    end
  end

  // Reset forces the idle output values regardless of the registered state.
  assign IFWrite    = reset | ifw;
  assign IDEXFlush  = ~reset & flush;
  assign PipeHold   = ~reset & hold;
  assign MemTimeout = ~reset & (state_q == ST_TIMEOUT);
  assign State      = reset ? 2'd0 : state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] lu_cnt_q, fl_cnt_q, mw_cnt_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      lu_cnt_q <= '0;
      fl_cnt_q <= '0;
      mw_cnt_q <= '0;
    end else begin
      lu_cnt_q <= sat_inc(lu_cnt_q, lu_stall);
      fl_cnt_q <= sat_inc(fl_cnt_q, br_flush);
      mw_cnt_q <= sat_inc(mw_cnt_q, hold);
    end
  end

  assign LuStallCnt = lu_cnt_q;
  assign FlushCnt   = fl_cnt_q;
  assign MemWaitCnt = mw_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       MemRead_ex;
  logic [4:0] WriteReg_ex;
  logic [4:0] Rs_id;
  logic [4:0] Rt_id;
  logic       UsesRt_id;
  logic       Branch;
  logic       MemReq_mem;
  logic       MemReady;
  logic       IFWrite;
  logic       IDEXFlush;
  logic       PipeHold;
  logic       MemTimeout;
  logic [1:0] State;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] LuStallCnt, FlushCnt, MemWaitCnt;
`endif

  int vectors     = 0;
  int miscompares = 0;

  // Expected {IFWrite, IDEXFlush, PipeHold, MemTimeout, State[1:0]}
  logic [5:0] exp_q[$];
  string      tag_q[$];

  always #5 clk = ~clk;

  hazard_ctrl #(.WAIT_MAX(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .MemRead_ex  (MemRead_ex),
    .WriteReg_ex (WriteReg_ex),
    .Rs_id       (Rs_id),
    .Rt_id       (Rt_id),
    .UsesRt_id   (UsesRt_id),
    .Branch      (Branch),
    .MemReq_mem  (MemReq_mem),
    .MemReady    (MemReady),
    .IFWrite     (IFWrite),
    .IDEXFlush   (IDEXFlush),
    .PipeHold    (PipeHold),
    .MemTimeout  (MemTimeout),
    .State       (State)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .LuStallCnt  (LuStallCnt),
    .FlushCnt    (FlushCnt),
    .MemWaitCnt  (MemWaitCnt)
`endif
  );

  task automatic clear_in();
    MemRead_ex  = 1'b0;
    WriteReg_ex = 5'd0;
    Rs_id       = 5'd0;
    Rt_id       = 5'd0;
    UsesRt_id   = 1'b0;
    Branch      = 1'b0;
    MemReq_mem  = 1'b0;
    MemReady    = 1'b0;
  endtask

  // Push the expectation, sample mid-cycle, then advance past the next edge.
  task automatic apply(input string tag, input logic [5:0] exp);
    logic [5:0] got, e;
    string      t;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge clk);
    got = {IFWrite, IDEXFlush, PipeHold, MemTimeout, State};
    e   = exp_q.pop_front();
    t   = tag_q.pop_front();
    vectors++;
    assert (got === e) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", t, got, e);
    end
    @(posedge clk);
    #1;
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic check_cnt(input string tag, input logic [31:0] lu_e,
                           input logic [31:0] fl_e, input logic [31:0] mw_e);
    vectors++;
    assert ({LuStallCnt, FlushCnt, MemWaitCnt} === {lu_e, fl_e, mw_e}) else begin
      miscompares++;
      $error("FAIL %s observed=%0d/%0d/%0d expected=%0d/%0d/%0d", tag,
             LuStallCnt, FlushCnt, MemWaitCnt, lu_e, fl_e, mw_e);
    end
  endtask
`endif

  initial begin
    clear_in();
    reset = 1'b1;
    @(posedge clk);
    #1;
    apply("reset", 6'b100000);
`ifdef HAZARD_PERF_CNT_EN
    check_cnt("cnt_reset", 0, 0, 0);
`endif
    reset = 1'b0;
    apply("idle", 6'b100000);

    // Load-use on rs
    MemRead_ex = 1'b1; WriteReg_ex = 5'd8; Rs_id = 5'd8;
    apply("lu_rs", 6'b010000);
    MemRead_ex = 1'b0;
    apply("lu_release", 6'b100000);

    // R0 never stalls
    MemRead_ex = 1'b1; WriteReg_ex = 5'd0; Rs_id = 5'd0;
    apply("lu_r0", 6'b100000);

    // rt match gated by UsesRt_id
    WriteReg_ex = 5'd9; Rs_id = 5'd1; Rt_id = 5'd9; UsesRt_id = 1'b0;
    apply("rt_unused", 6'b100000);
    UsesRt_id = 1'b1;
    apply("rt_used", 6'b010000);

    // Branch overrides load-use
    Branch = 1'b1;
    apply("branch_over_lu", 6'b110000);
    clear_in();

    // Memory wait, 3 hold cycles, Branch held high throughout
    MemReq_mem = 1'b1; Branch = 1'b1;
    apply("mw_enter", 6'b001000);
    apply("mw_wait1", 6'b001001);
    apply("mw_wait2", 6'b001001);
    MemReady = 1'b1;
    apply("mw_ack", 6'b110001);
    clear_in();
    apply("mw_back_run", 6'b100000);

    // Acknowledged in first cycle: no hold
    MemReq_mem = 1'b1; MemReady = 1'b1;
    apply("mem_fast_ack", 6'b100000);
    clear_in();
`ifdef HAZARD_PERF_CNT_EN
    check_cnt("cnt_after_scenarios", 2, 2, 3);
`endif

    // Timeout with WAIT_MAX=4: five hold cycles, then TIMEOUT
    MemReq_mem = 1'b1;
    apply("to_enter", 6'b001000);
    for (int i = 1; i <= 4; i++) apply($sformatf("to_wait%0d", i), 6'b001001);
    apply("to_reached", 6'b001110);
    MemReq_mem = 1'b0; MemReady = 1'b1;
    apply("to_late_ready", 6'b001110);
    clear_in();
    apply("to_sticky", 6'b001110);
    reset = 1'b1;
    apply("to_reset", 6'b100000);
    reset = 1'b0;
    apply("to_after_reset", 6'b100000);

    // Reset in mid-MEM_WAIT clears state and counters
    MemReq_mem = 1'b1;
    apply("mid_enter", 6'b001000);
    apply("mid_wait", 6'b001001);
    reset = 1'b1;
    apply("mid_reset", 6'b100000);
    reset = 1'b0;
    clear_in();
`ifdef HAZARD_PERF_CNT_EN
    check_cnt("cnt_mid_reset", 0, 0, 0);
`endif
    apply("mid_after_reset", 6'b100000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage MIPS core. It sequences the IF stage's `IFWrite` enable and the downstream pipeline registers.
- Inserts load-use bubbles.
- Squashes the ID instruction on a taken branch.
- Freezes the whole pipeline while the data memory is busy.
- Flags a memory timeout.

It sits beside the IF stage and drives the ID/EX, EX/MEM and MEM/WB register enables and flushes.

## Interface
Parameters:
- `WAIT_MAX`, 16: maximum consecutive memory-wait cycles before timeout; legal range 1..255.

Ports:
- `clk` in 1: the single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `MemRead_ex` in 1: the instruction in EX is a load.
- `WriteReg_ex` in 5: the load's destination register.
- `Rs_id` in 5: rs of the instruction in ID.
- `Rt_id` in 5: rt of the instruction in ID.
- `UsesRt_id` in 1: the ID instruction reads rt.
- `Branch` in 1: taken branch resolved in EX; the same signal also feeds IF.
- `MemReq_mem` in 1: the MEM stage is performing a load or store.
- `MemReady` in 1: data memory acknowledges this cycle.
- `IFWrite` out 1: PC and IF/ID enable.
- `IDEXFlush` out 1: load a bubble into ID/EX.
- `PipeHold` out 1: freeze ID/EX, EX/MEM and MEM/WB.
- `MemTimeout` out 1: sticky error.
- `State` out 2: current FSM state, for debug.

## Operation
FSM states:
- `RUN`, encoded 0.
- `MEM_WAIT`, encoded 1.
- `TIMEOUT`, encoded 2.

Load-use hazard `lu` is asserted when all of the following hold:
- `MemRead_ex` = 1.
- `WriteReg_ex` != 0.
- `WriteReg_ex` == `Rs_id`, or (`UsesRt_id` and `WriteReg_ex` == `Rt_id`).

In `RUN`, outputs are combinational, evaluated in priority order:
1. If `MemReq_mem` && !`MemReady`: `PipeHold`=1, `IFWrite`=0, `IDEXFlush`=0; next state `MEM_WAIT`, wait counter ← 1.
2. Else if `Branch`: `IFWrite`=1, `IDEXFlush`=1. The branch overrides `lu`, because the stalled instruction is squashed anyway.
3. Else if `lu`: `IFWrite`=0, `IDEXFlush`=1. Exactly one bubble results, since the load advances to MEM next cycle.
4. Else: `IFWrite`=1, `IDEXFlush`=0, `PipeHold`=0.

In `MEM_WAIT`:
- `PipeHold`=1, `IFWrite`=0, `IDEXFlush`=0 every cycle. `Branch` and `lu` are ignored; both are re-evaluated after release, since the EX instruction is frozen.
- On `MemReady`=1: outputs go to the `RUN` values in that same cycle (`PipeHold`=0); next state `RUN`, counter cleared.
- Else, if counter == `WAIT_MAX`: next state `TIMEOUT`.
- Else: counter increments.

`TIMEOUT`:
- `PipeHold`=1, `IFWrite`=0, `MemTimeout`=1.
- Only `reset` leaves this state; a late `MemReady` is ignored.

`MemTimeout` is 1 only in `TIMEOUT`.

Reset:
- While `reset`=1: state ← `RUN`, counter ← 0.
- Outputs during reset: `IFWrite`=1, `IDEXFlush`=0, `PipeHold`=0, `MemTimeout`=0, `State`=0.
- Reset has priority over every event, including mid-`MEM_WAIT` and `TIMEOUT`.

## Timing
- Hazard response has 0-cycle latency: `IFWrite`, `IDEXFlush` and `PipeHold` react in the same cycle as their inputs.
- `State` and `MemTimeout` are registered; they change one edge after the triggering condition.
- A memory access acknowledged in its first cycle (`MemReady`=1 with `MemReq_mem`) produces no hold.
- A memory access that stalls holds for exactly the number of cycles until `MemReady`.
- Timeout: entering `MEM_WAIT` at edge 0, `TIMEOUT` is reached at edge `WAIT_MAX` if `MemReady` never arrives, giving `WAIT_MAX`+1 hold cycles.
- The wait counter is 8 bits and never wraps.

## Configuration
Macro: `HAZARD_PERF_CNT_EN`.
- When defined, adds three 32-bit output counters:
  - `LuStallCnt`: cycles with `lu` stalling.
  - `FlushCnt`: cycles with branch flush.
  - `MemWaitCnt`: cycles with `PipeHold`=1.
- The counters saturate at 0xFFFFFFFF and are cleared by `reset`.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

## Structure
- Shared package `hazard_pkg` holds:
  - the state encoding constants `ST_RUN`, `ST_MEM_WAIT`, `ST_TIMEOUT`;
  - the 5-bit register-index width;
  - the 8-bit wait-counter width.
- Sub-module `wait_timer` contains the wait counter with its clear, increment and expiry compare against `WAIT_MAX`.
- The FSM and hazard comparators stay in `hazard_ctrl`.

## Test plan
- Load-use: `MemRead_ex`=1, `WriteReg_ex`=8, `Rs_id`=8, other inputs 0 → one cycle with `IFWrite`=0, `IDEXFlush`=1. The next cycle, with `MemRead_ex`=0, → `IFWrite`=1.
- R0 and rt gating:
  - `WriteReg_ex`=0 = `Rs_id` → no stall.
  - `Rt_id`=9 match with `UsesRt_id`=0 → no stall; with `UsesRt_id`=1 → stall.
- Branch over load-use: `Branch`=1 together with an `lu` condition → `IFWrite`=1, `IDEXFlush`=1 for 1 cycle.
- Memory wait: `MemReq_mem`=1 with `MemReady` low for 3 cycles then high → `PipeHold`=1 for 3 cycles, `State` shows 1, then `RUN` with `PipeHold`=0 in the ack cycle. `Branch` held high throughout → `IDEXFlush` stays 0 until the ack cycle.
- Timeout: `WAIT_MAX`=4, `MemReady` never asserted → `State`=2 and `MemTimeout`=1 after the 4th edge in wait. A later `MemReady` has no effect; `reset` pulse → all outputs return to reset values.
- With `HAZARD_PERF_CNT_EN` defined, the previous scenarios produce matching counter values, e.g. `MemWaitCnt`=3 after the memory-wait scenario. `reset` in mid-`MEM_WAIT` → state `RUN` and counters 0 next cycle.
